// File: rtl/qsc_pkg.sv
// Shared types and helpers for the quadrature speed counter.
// Build option: define QSC_QUAD_EN for 4x quadrature decoding with signed counts;
// leave it undefined for unsigned counting of synchronised A rising edges only.
package qsc_pkg;

`ifdef QSC_QUAD_EN
    localparam bit QUAD_EN = 1'b1;
`else
    localparam bit QUAD_EN = 1'b0;
`endif

    // Quadrature state as {A, B}; forward (A leads B) walks 00 -> 10 -> 11 -> 01 -> 00
    typedef enum logic [1:0] {
        QS_00 = 2'b00,
        QS_10 = 2'b10,
        QS_11 = 2'b11,
        QS_01 = 2'b01
    } qstate_e;

    // Per-cycle accumulator action produced by the decoder
    typedef enum logic [1:0] {
        INC_NONE = 2'd0,
        INC_UP   = 2'd1,
        INC_DN   = 2'd2,
        INC_ERR  = 2'd3
    } inc_e;

    // Next state in the forward direction
    function automatic qstate_e qs_fwd(qstate_e s);
        case (s)
            QS_00:   return QS_10;
            QS_10:   return QS_11;
            QS_11:   return QS_01;
            default: return QS_00;
        endcase
    endfunction

    // Largest accumulator value for a count width w (signed when quadrature is enabled)
    function automatic logic [31:0] sat_max(int unsigned w);
        logic [32:0] one;
        one = 33'd1;
        if (QUAD_EN) return 32'((one << (w - 1)) - 33'd1);
        else         return 32'((one << w) - 33'd1);
    endfunction

    // Smallest accumulator value for a count width w, as a w-bit pattern
    function automatic logic [31:0] sat_min(int unsigned w);
        logic [32:0] one;
        one = 33'd1;
        if (QUAD_EN) return 32'(one << (w - 1));
        else         return 32'd0;
    endfunction

endpackage

// File: rtl/qsc_channel.sv
// One encoder channel: synchroniser, transition decoder, saturating accumulator and
// sticky overflow/error flags. Build option QSC_QUAD_EN selects 4x quadrature decoding.
// The o_*_nxt outputs already include this cycle's event so the top can latch them
// directly in the terminal cycle of a window; i_clear restarts the channel afterwards.
module qsc_channel
    import qsc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enc_a,
    input  logic             i_enc_b,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_acc_nxt,
    output logic             o_ovf_nxt,
    output logic             o_err_nxt
);

    localparam logic [31:0]      MAX32   = sat_max(CNT_W);
    localparam logic [31:0]      MIN32   = sat_min(CNT_W);
    localparam logic [CNT_W-1:0] LIM_MAX = MAX32[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LIM_MIN = MIN32[CNT_W-1:0];

    inc_e             w_inc;
    inc_e             r_inc;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] w_acc_nxt;
    logic             r_ovf;
    logic             r_err;
    logic             w_sat;
    logic             w_err_ev;

`ifdef QSC_QUAD_EN
    logic [1:0] r_s1;
    logic [1:0] r_s2;
    logic [1:0] r_h;

    // Two-flop synchroniser for {A, B} followed by the history flop
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 2'b00;
            r_s2 <= 2'b00;
            r_h  <= 2'b00;
        end else begin
            r_s1 <= {i_enc_a, i_enc_b};
            r_s2 <= r_s1;
            r_h  <= r_s2;
        end
    end

    // Decode history -> current: one bit changed is a step, both changed is illegal
    always_comb begin
        w_inc = INC_NONE;
        if (r_s2 == r_h) begin
            w_inc = INC_NONE;
        end else if ((r_s2 ^ r_h) == 2'b11) begin
            w_inc = INC_ERR;
        end else if (r_s2 == qs_fwd(qstate_e'(r_h))) begin
            w_inc = INC_UP;
        end else begin
            w_inc = INC_DN;
        end
    end
`else
    logic r_s1;
    logic r_s2;
    logic r_h;
    logic w_unused_b;

    assign w_unused_b = i_enc_b;

    // Two-flop synchroniser for A followed by the history flop
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_h  <= 1'b0;
        end else begin
            r_s1 <= i_enc_a;
            r_s2 <= r_s1;
            r_h  <= r_s2;
        end
    end

    // Count rising edges of synchronised A only
    always_comb begin
        w_inc = INC_NONE;
        if (r_s2 && !r_h) w_inc = INC_UP;
    end
`endif

    // Apply this cycle's increment with saturation, and collect the flag events
    always_comb begin
        w_acc_nxt = r_acc;
        w_sat     = 1'b0;
        w_err_ev  = 1'b0;
        unique case (r_inc)
            INC_UP: begin
                if (r_acc == LIM_MAX) w_sat = 1'b1;
                else                  w_acc_nxt = r_acc + CNT_W'(1);
            end
            INC_DN: begin
                if (r_acc == LIM_MIN) w_sat = 1'b1;
                else                  w_acc_nxt = r_acc - CNT_W'(1);
            end
            INC_ERR: w_err_ev = 1'b1;
            default: ;
        endcase
    end

    // Registered increment (sets the 3-cycle input-to-count latency), accumulator, flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inc <= INC_NONE;
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_inc <= w_inc;
            if (i_clear) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
                r_err <= 1'b0;
            end else begin
                r_acc <= w_acc_nxt;
                r_ovf <= r_ovf | w_sat;
                r_err <= r_err | w_err_ev;
            end
        end
    end

    assign o_acc_nxt = w_acc_nxt;
    assign o_ovf_nxt = r_ovf | w_sat;
    assign o_err_nxt = r_err | w_err_ev;

endmodule

// File: rtl/quad_speed_counter.sv
// Multi-channel encoder speed counter: counts encoder transitions over a fixed window of
// WIN_CYCLES clocks and publishes the per-channel count with overflow/error flags.
// Build option QSC_QUAD_EN: 4x quadrature decoding with signed speed; otherwise unsigned
// counting of A rising edges with err held at 0.
module quad_speed_counter
    import qsc_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WIN_CYCLES = 200000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_CH-1:0]       enc_a,
    input  logic [N_CH-1:0]       enc_b,
    output logic [N_CH*CNT_W-1:0] speed,
    output logic [N_CH-1:0]       ovf,
    output logic [N_CH-1:0]       err,
    output logic                  sample_valid
);

    localparam int unsigned      WIN_W    = $clog2(WIN_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

    logic                  r_run;
    logic [WIN_W-1:0]      r_win;
    logic                  w_term;
    logic [N_CH*CNT_W-1:0] w_acc_nxt;
    logic [N_CH-1:0]       w_ovf_nxt;
    logic [N_CH-1:0]       w_err_nxt;
    logic [N_CH*CNT_W-1:0] r_speed;
    logic [N_CH-1:0]       r_ovf;
    logic [N_CH-1:0]       r_err;
    logic                  r_valid;

    assign w_term = r_run && (r_win == WIN_LAST);

    // Shared window counter; r_run holds it at 0 for the first cycle after reset release
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_run <= 1'b0;
            r_win <= '0;
        end else begin
            r_run <= 1'b1;
            if (r_run) r_win <= w_term ? '0 : r_win + WIN_W'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        qsc_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clk     (CLK),
            .i_rst     (RST),
            .i_enc_a   (enc_a[g]),
            .i_enc_b   (enc_b[g]),
            .i_clear   (w_term),
            .o_acc_nxt (w_acc_nxt[g*CNT_W +: CNT_W]),
            .o_ovf_nxt (w_ovf_nxt[g]),
            .o_err_nxt (w_err_nxt[g])
        );
    end

    // Latch the closing window's results in the terminal cycle; hold them otherwise
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_speed <= '0;
            r_ovf   <= '0;
            r_err   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_term;
            if (w_term) begin
                r_speed <= w_acc_nxt;
                r_ovf   <= w_ovf_nxt;
                r_err   <= w_err_nxt;
            end
        end
    end

    assign speed        = r_speed;
    assign ovf          = r_ovf;
    assign err          = r_err;
    assign sample_valid = r_valid;

endmodule

// File: doc/quad_speed_counter.md
QUAD_SPEED_COUNTER -- requirements
Module: quad_speed_counter

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of encoder channels, 1..8.
REQ-002 SHALL have parameter CNT_W, default 16: per-channel count width, 4..32.
REQ-003 SHALL have parameter WIN_CYCLES, default 200000: measurement window length in CLK cycles, >= 4.
REQ-004 SHALL have port CLK, input, 1 bit: sole clock; all logic is on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port enc_a, input, N_CH bits: encoder channel A per channel; asynchronous to CLK.
REQ-007 SHALL have port enc_b, input, N_CH bits: encoder channel B per channel; asynchronous to CLK.
REQ-008 SHALL have port speed, output, N_CH*CNT_W bits: latched count of the last window, channel i at bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port ovf, output, N_CH bits: the channel saturated during the last window.
REQ-010 SHALL have port err, output, N_CH bits: an illegal quadrature transition occurred during the last window.
REQ-011 SHALL have port sample_valid, output, 1 bit: one-cycle pulse when speed, ovf and err update.

Function
REQ-012 SHALL pass each enc_a/enc_b bit through a 2-flop synchroniser, then one history flop for edge detection.
REQ-013 SHALL count an input transition into the accumulator exactly 3 CLK cycles after it reaches the first synchroniser flop.
REQ-014 SHALL run a window counter from 0 to WIN_CYCLES-1 and wrap to 0; the terminal cycle is the cycle the counter equals WIN_CYCLES-1.
REQ-015 SHALL, in the terminal cycle, latch into speed/ovf/err the accumulator plus that cycle's increment, and the sticky flags including that cycle's events.
REQ-016 SHALL restart the accumulator at 0 and clear the sticky flags in the cycle after the terminal cycle.
REQ-017 SHALL pulse sample_valid high for exactly the one cycle after the terminal cycle, aligned with the new speed value.
REQ-018 SHALL saturate the accumulator at its maximum or minimum, never wrap, and set the channel's sticky ovf flag on any saturated increment.
REQ-019 SHALL treat a sampled change of both A and B in the same cycle as illegal: no count, and the channel's sticky err flag is set.
REQ-020 SHALL hold speed, ovf and err stable between sample_valid pulses.
REQ-021 SHALL process each channel independently, with one shared window counter.

Reset
REQ-022 SHALL, while RST is high, asynchronously clear all synchronisers, history flops, accumulators, the window counter, speed, ovf, err and sample_valid to 0.
REQ-023 SHALL, after RST is released mid-window, discard the partial window and issue the first sample_valid WIN_CYCLES+1 cycles after the first rising CLK edge with RST low.

Configuration
REQ-024 SHALL, with macro QSC_QUAD_EN defined, perform 4x quadrature decoding and return speed as two's-complement signed.
REQ-025 SHALL, under QSC_QUAD_EN, count +1 for each A-leads-B edge and -1 for each B-leads-A edge.
REQ-026 SHALL, without QSC_QUAD_EN, count +1 only on each rising edge of synchronised A, return speed as unsigned, ignore enc_b, and tie err to 0.

Structure
REQ-027 SHALL declare in package qsc_pkg: the quadrature-state encoding, the increment enum (INC_NONE, INC_UP, INC_DN, INC_ERR), and the saturation limit functions parameterised by CNT_W.
REQ-028 SHALL place synchroniser, decoder, accumulator and sticky flags in sub-module qsc_channel, instantiated N_CH times.
REQ-029 SHALL keep the window counter and the output latching logic in the top module.

Verification
Bench parameters: WIN_CYCLES=100, CNT_W=8, N_CH=2, QSC_QUAD_EN defined unless stated.
REQ-030 SHALL verify that ch0 driven forward 10 full quadrature periods (40 edges) in one window -> speed[7:0]=+40, ovf=0, err=0, sample_valid pulse every 100 cycles.
REQ-031 SHALL verify that ch1 driven reverse 5 periods while ch0 stays idle -> ch1 speed=-20 (8'hEC) and ch0 speed=0 in the same sample.
REQ-032 SHALL verify that 200 forward edges in one window -> speed=+127, ovf=1; the next window with 3 edges -> speed=3, ovf=0.
REQ-033 SHALL verify that A and B toggled in the same CLK cycle -> count unchanged, err=1 for that window only.
REQ-034 SHALL verify that an edge whose counted cycle is the terminal cycle lands in the closing window's speed, not the next window's.
REQ-035 SHALL verify that RST pulsed at window cycle 50 -> all outputs 0 immediately, and the next sample_valid comes 101 cycles after release; without QSC_QUAD_EN, 30 A rising edges -> speed=30.
